// File: rtl/cpu_trace_buffer.sv
// Instruction trace buffer: captures filtered {PC, instruction, control, stamp}
// records into a circular store, with halt detection and a streaming read port.
module cpu_trace_buffer #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 16,
   parameter int STAMP_W  = 32,
   parameter int HALT_CYC = 4
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic [ADDR_W-1:0]        Pc_out,
   input  logic [DATA_W-1:0]        InstMem_out,
   input  logic [10:0]              Ctrl,
   input  logic                     Arm,
   input  logic                     Flush,
   input  logic [1:0]               Mode,
   input  logic                     Wrap,
   input  logic                     Rd_Ready,
   output logic                     Rd_Valid,
   output logic [ADDR_W-1:0]        Rd_Pc,
   output logic [DATA_W-1:0]        Rd_Inst,
   output logic [10:0]              Rd_Ctrl,
   output logic [STAMP_W-1:0]       Rd_Stamp,
   output logic [$clog2(DEPTH):0]   Count,
   output logic [1:0]               State,
   output logic                     Halted,
   output logic                     Dropped
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int RW = $clog2(HALT_CYC + 1);
   localparam int EW = ADDR_W + DATA_W + 11 + STAMP_W;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_STOPPED = 2'd2
   } state_t;

   state_t              state;
   logic [EW-1:0]       mem [DEPTH];
   logic [EW-1:0]       head;
   logic [PW-1:0]       wptr, rptr;
   logic [CW-1:0]       count;
   logic [STAMP_W-1:0]  stamp;
   logic [ADDR_W-1:0]   prev_pc;
   logic [RW-1:0]       run, run_nxt;
   logic                halted, dropped;
   logic                filt, cap, pop, full, store, overwrite, stall, halt_hit;

   always_comb begin
      filt = 1'b0;
      case (Mode)
         2'd0:    filt = 1'b1;
         2'd1:    filt = Ctrl[9] | Ctrl[8];
         2'd2:    filt = Ctrl[7] | Ctrl[5];
         default: filt = 1'b0;
      endcase
      full      = (count == CW'(DEPTH));
      cap       = (state == S_CAPTURE) && filt && !Flush;
      pop       = (count != '0) && Rd_Ready && !Flush;
      // A pop in the same cycle frees the slot, so a full buffer never overwrites then.
      store     = cap && (!full || pop || Wrap);
      overwrite = cap && full && !pop && Wrap;
      stall     = cap && full && !pop && !Wrap;
      if (Pc_out != prev_pc)
         run_nxt = '0;
      else if (run == RW'(HALT_CYC))
         run_nxt = run;
      else
         run_nxt = run + RW'(1);
      halt_hit  = (state == S_CAPTURE) && (run_nxt == RW'(HALT_CYC));
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state   <= S_IDLE;
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
         stamp   <= '0;
         prev_pc <= '0;
         run     <= '0;
         halted  <= 1'b0;
         dropped <= 1'b0;
      end else begin
         stamp   <= stamp + STAMP_W'(1);
         prev_pc <= Pc_out;
         run     <= run_nxt;
         if (Flush) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            dropped <= 1'b0;
         end else begin
            if (store)
               wptr <= wptr + PW'(1);
            if (pop || overwrite)
               rptr <= rptr + PW'(1);
            if (store && !pop && !overwrite)
               count <= count + CW'(1);
            else if (pop && !store)
               count <= count - CW'(1);
            if (overwrite)
               dropped <= 1'b1;
         end
         case (state)
            S_IDLE:
               if (Arm) state <= S_CAPTURE;
            S_CAPTURE:
               if (halt_hit || stall) begin
                  state <= S_STOPPED;
                  if (halt_hit) halted <= 1'b1;
               end
            S_STOPPED:
               if (Arm) begin
                  state  <= S_CAPTURE;
                  halted <= 1'b0;
               end
            default:
               state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (store)
         mem[wptr] <= {Pc_out, InstMem_out, Ctrl, stamp};
   end

   assign head     = mem[rptr];
   assign Rd_Valid = (count != '0);
   assign Rd_Pc    = Rd_Valid ? head[EW-1 -: ADDR_W]           : '0;
   assign Rd_Inst  = Rd_Valid ? head[EW-ADDR_W-1 -: DATA_W]    : '0;
   assign Rd_Ctrl  = Rd_Valid ? head[STAMP_W +: 11]            : '0;
   assign Rd_Stamp = Rd_Valid ? head[STAMP_W-1:0]              : '0;
   assign Count    = count;
   assign State    = state;
   assign Halted   = halted;
   assign Dropped  = dropped;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based reference model.
module tb_cpu_trace_buffer;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int D  = 16;
   localparam int SW = 32;
   localparam int HC = 4;

   logic          Clk = 1'b0;
   logic          Rst;
   logic [AW-1:0] Pc_out;
   logic [DW-1:0] InstMem_out;
   logic [10:0]   Ctrl;
   logic          Arm, Flush, Wrap, Rd_Ready;
   logic [1:0]    Mode;
   logic          Rd_Valid;
   logic [AW-1:0] Rd_Pc;
   logic [DW-1:0] Rd_Inst;
   logic [10:0]   Rd_Ctrl;
   logic [SW-1:0] Rd_Stamp;
   logic [4:0]    Count;
   logic [1:0]    State;
   logic          Halted, Dropped;

   always #5 Clk = ~Clk;

   cpu_trace_buffer #(
      .ADDR_W(AW), .DATA_W(DW), .DEPTH(D), .STAMP_W(SW), .HALT_CYC(HC)
   ) dut (
      .Clk(Clk), .Rst(Rst), .Pc_out(Pc_out), .InstMem_out(InstMem_out),
      .Ctrl(Ctrl), .Arm(Arm), .Flush(Flush), .Mode(Mode), .Wrap(Wrap),
      .Rd_Ready(Rd_Ready), .Rd_Valid(Rd_Valid), .Rd_Pc(Rd_Pc), .Rd_Inst(Rd_Inst),
      .Rd_Ctrl(Rd_Ctrl), .Rd_Stamp(Rd_Stamp), .Count(Count), .State(State),
      .Halted(Halted), .Dropped(Dropped)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference model: a queue of records plus a few scalar flags.
   typedef struct {
      logic [AW-1:0] pc;
      logic [DW-1:0] inst;
      logic [10:0]   ctrl;
      logic [SW-1:0] stamp;
   } ent_t;

   ent_t          q[$];
   int            m_state;
   bit            m_halted, m_dropped;
   logic [SW-1:0] m_stamp;
   logic [AW-1:0] m_prev;
   int            m_run;

   function automatic bit filt(input logic [1:0] md, input logic [10:0] c);
      case (md)
         2'd0:    return 1'b1;
         2'd1:    return c[9] | c[8];
         2'd2:    return c[7] | c[5];
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      q.delete();
      m_state = 0; m_halted = 0; m_dropped = 0;
      m_stamp = '0; m_prev = '0; m_run = 0;
   endtask

   task automatic model_edge();
      bit cap, pop, hit, stopf;
      ent_t e;
      if (Rst) begin
         model_reset();
         return;
      end
      cap   = (m_state == 1) && filt(Mode, Ctrl) && !Flush;
      pop   = (q.size() > 0) && Rd_Ready && !Flush;
      m_run = (Pc_out == m_prev) ? m_run + 1 : 0;
      hit   = (m_state == 1) && (m_run >= HC);
      stopf = 0;
      e = '{pc: Pc_out, inst: InstMem_out, ctrl: Ctrl, stamp: m_stamp};
      if (Flush) begin
         q.delete();
         m_dropped = 0;
      end else begin
         if (pop) void'(q.pop_front());
         if (cap) begin
            if (q.size() < D) q.push_back(e);
            else if (Wrap) begin
               void'(q.pop_front());
               q.push_back(e);
               m_dropped = 1;
            end else stopf = 1;
         end
      end
      case (m_state)
         0: if (Arm) m_state = 1;
         1: if (hit || stopf) begin
               m_state = 2;
               if (hit) m_halted = 1;
            end
         default: if (Arm) begin
               m_state = 1;
               m_halted = 0;
            end
      endcase
      m_prev  = Pc_out;
      m_stamp = m_stamp + 1;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".count"},   Count,    q.size());
      check({tag, ".valid"},   Rd_Valid, q.size() != 0);
      check({tag, ".state"},   State,    m_state);
      check({tag, ".halted"},  Halted,   m_halted);
      check({tag, ".dropped"}, Dropped,  m_dropped);
      if (q.size() != 0) begin
         check({tag, ".pc"},    Rd_Pc,    q[0].pc);
         check({tag, ".inst"},  Rd_Inst,  q[0].inst);
         check({tag, ".ctrl"},  Rd_Ctrl,  q[0].ctrl);
         check({tag, ".stamp"}, Rd_Stamp, q[0].stamp);
      end
   endtask

   task automatic step(input string tag);
      @(posedge Clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic idle_inputs();
      Arm = 0; Flush = 0; Rd_Ready = 0; Mode = 2'd0; Wrap = 0;
      Ctrl = '0; Pc_out = '0; InstMem_out = '0;
   endtask

   // Assert reset between edges and check outputs before the next edge.
   task automatic async_reset();
      #2;
      Rst = 1;
      model_reset();
      #1;
      check_all("arst");
      check("arst.rd_pc",    Rd_Pc,    0);
      check("arst.rd_inst",  Rd_Inst,  0);
      check("arst.rd_ctrl",  Rd_Ctrl,  0);
      check("arst.rd_stamp", Rd_Stamp, 0);
      step("arst_hold");
      Rst = 0;
      idle_inputs();
   endtask

   task automatic arm_capture(input logic [1:0] md, input logic wr);
      Mode = md; Wrap = wr; Pc_out = 32'h1000; Arm = 1;
      step("arm");
      Arm = 0;
   endtask

   initial begin
      logic [SW-1:0] arm_stamp;
      logic [10:0]   rc;
      logic [10:0]   c;

      Rst = 1;
      idle_inputs();
      model_reset();
      step("reset");
      check("reset.rd_pc", Rd_Pc, 0);
      Rst = 0;
      step("idle");

      // Stop-on-full capture.
      arm_stamp = m_stamp - 1;
      arm_capture(2'd0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         Pc_out = i * 4; InstMem_out = $urandom; Ctrl = 11'($urandom);
         step("full_stop");
      end
      check("t1.count", Count, 16);
      check("t1.state", State, 2);
      check("t1.pc",    Rd_Pc, 0);
      check("t1.stamp", Rd_Stamp, arm_stamp + 2);

      // Wrap-around capture.
      async_reset();
      arm_capture(2'd0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         Pc_out = i * 4; InstMem_out = $urandom; Ctrl = 11'($urandom);
         step("wrap");
      end
      check("t2.count",   Count, 16);
      check("t2.dropped", Dropped, 1);
      check("t2.pc",      Rd_Pc, 16);
      check("t2.state",   State, 1);

      // Branch/jump filter.
      async_reset();
      arm_capture(2'd1, 1'b0);
      for (int i = 0; i < 11; i++) begin
         c = 11'($urandom) & 11'h4FF;
         if (i * 4 == 8 || i * 4 == 32) c = c | 11'h100;
         Pc_out = i * 4; InstMem_out = $urandom; Ctrl = c;
         step("filter");
      end
      check("t3.count", Count, 2);
      check("t3.pc0",   Rd_Pc, 32'h8);
      rc = Rd_Ctrl;
      check("t3.branch0", rc[8], 1);
      Rd_Ready = 1;
      step("filter_pop");
      Rd_Ready = 0;
      check("t3.pc1", Rd_Pc, 32'h20);
      rc = Rd_Ctrl;
      check("t3.branch1", rc[8], 1);

      // Halt detection and re-arm.
      async_reset();
      arm_capture(2'd0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         Pc_out = 32'h40; InstMem_out = $urandom; Ctrl = 11'($urandom);
         step("halt");
      end
      check("t4.halted", Halted, 1);
      check("t4.state",  State, 2);
      check("t4.count",  Count, 5);
      Pc_out = 32'h100; Arm = 1;
      step("rearm");
      Arm = 0;
      check("t4.rearm_state",  State, 1);
      check("t4.rearm_halted", Halted, 0);
      check("t4.rearm_count",  Count, 5);

      // Full buffer with concurrent reads, then flush.
      async_reset();
      arm_capture(2'd0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         Pc_out = 32'h2000 + i * 4; InstMem_out = $urandom; Ctrl = 11'($urandom);
         step("fill");
      end
      check("t5.full", Count, 16);
      Rd_Ready = 1;
      for (int i = 16; i < 26; i++) begin
         Pc_out = 32'h2000 + i * 4; InstMem_out = $urandom;
         step("stream");
         check("t5.stream_count", Count, 16);
         check("t5.stream_drop",  Dropped, 0);
      end
      Flush = 1; Pc_out = 32'h3000;
      step("flush");
      Flush = 0;
      check("t5.flush_count", Count, 0);
      check("t5.flush_valid", Rd_Valid, 0);
      Pc_out = 32'h3004;
      step("post_flush");

      // Randomized traffic, with a reset landing mid-capture first.
      async_reset();
      for (int i = 0; i < 800; i++) begin
         Arm      = ($urandom % 12) == 0;
         Flush    = ($urandom % 40) == 0;
         Mode     = 2'($urandom);
         Wrap     = 1'($urandom);
         Rd_Ready = ($urandom % 3) == 0;
         Ctrl     = 11'($urandom);
         Pc_out   = ($urandom % 3) * 4;
         InstMem_out = $urandom;
         if (($urandom % 250) == 0) async_reset();
         else step("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/cpu_trace_buffer.md
CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 Parameter ADDR_W, default 32, PC width.
REQ-002 Parameter DATA_W, default 32, instruction width.
REQ-003 Parameter DEPTH, default 16, entry count; power of two, >=2.
REQ-004 Parameter STAMP_W, default 32, cycle-stamp width.
REQ-005 Parameter HALT_CYC, default 4, consecutive equal-PC cycles declaring halt; >=1.
REQ-006 Clk  in  1  single clock; all state updates on rising edge.
REQ-007 Rst  in  1  reset, asynchronous, active-high.
REQ-008 Pc_out  in  ADDR_W  CPU PC, sampled each cycle.
REQ-009 InstMem_out  in  DATA_W  instruction at Pc_out.
REQ-010 Ctrl  in  11  {RegDest,Jump,Branch,Sig_Mem_Read,Sig_Mem_to_Reg,Sig_Mem_Write,ALUSrc,Sig_Reg_Write,ALUOp[2:0]}, MSB first.
REQ-011 Arm  in  1  pulse: enter CAPTURE.
REQ-012 Flush  in  1  pulse: empty buffer, clear Dropped.
REQ-013 Mode  in  2  capture filter: 0 all, 1 Jump|Branch, 2 Sig_Mem_Read|Sig_Mem_Write, 3 none.
REQ-014 Wrap  in  1  1 = overwrite oldest when full; 0 = stop when full.
REQ-015 Rd_Ready  in  1  consumer accepts head entry.
REQ-016 Rd_Valid  out  1  buffer non-empty.
REQ-017 Rd_Pc / Rd_Inst / Rd_Ctrl / Rd_Stamp  out  ADDR_W / DATA_W / 11 / STAMP_W  head entry fields.
REQ-018 Count  out  $clog2(DEPTH)+1  entries held.
REQ-019 State  out  2  0 IDLE, 1 CAPTURE, 2 STOPPED.
REQ-020 Halted  out  1  sticky halt detected.
REQ-021 Dropped  out  1  sticky: an entry was overwritten.

Function
REQ-022 Free-running stamp counter increments every cycle from 0, wraps modulo 2^STAMP_W; captured entry stamp = counter value in the capture cycle.
REQ-023 Qualified write = State==CAPTURE and Mode filter true on current Ctrl; entry = {Pc_out,InstMem_out,Ctrl,stamp}, visible on Rd_* one cycle later if buffer was empty.
REQ-024 Read handshake: pop when Rd_Valid && Rd_Ready; Rd_* hold stable while Rd_Valid && !Rd_Ready; Rd_* don't-care when !Rd_Valid.
REQ-025 Simultaneous pop and write: both occur, Count unchanged, including when full (no overwrite, Dropped unaffected).
REQ-026 Write when full, no pop, Wrap=1: oldest entry discarded, new entry stored, Count stays DEPTH, Dropped set.
REQ-027 Write when full, no pop, Wrap=0: write discarded, State -> STOPPED next cycle.
REQ-028 Pointers wrap modulo DEPTH; Count never exceeds DEPTH nor underflows (pop on empty ignored).
REQ-029 FSM: IDLE -Arm-> CAPTURE; CAPTURE -halt or REQ-027-> STOPPED; STOPPED -Arm-> CAPTURE (Halted cleared, buffer kept); Arm in CAPTURE no effect.
REQ-030 Halt detect: equal-PC run counter increments when Pc_out equals previous-cycle Pc_out, else clears; reaching HALT_CYC in CAPTURE sets Halted and State -> STOPPED; the triggering cycle's qualified write is still stored.
REQ-031 Flush: next cycle Count=0, Rd_Valid=0, Dropped=0; same-cycle write and pop discarded; State unchanged; Flush has priority over Arm effects on buffer only.
REQ-032 Readout permitted in every state.

Reset
REQ-033 Rst asserted: immediately State=IDLE, Count=0, Rd_Valid=0, Halted=0, Dropped=0, stamp=0, run counter=0, pointers=0, previous-PC register=0; Rd_* data=0.
REQ-034 Reset mid-capture or mid-readout discards all entries; first edge after release behaves as IDLE.

Verification
REQ-035 Mode 0, Wrap 0, DEPTH 16, Arm, PC 0,4,8,... for 20 cycles, Rd_Ready=0 -> Count=16, State=STOPPED, first read Rd_Pc=0, Rd_Stamp=arm cycle+1 stamp.
REQ-036 Same with Wrap=1, 20 captures -> Count=16, Dropped=1, head Rd_Pc=16 (fifth entry).
REQ-037 Mode 1, Branch high only on PCs 0x8 and 0x20 -> exactly 2 entries, Rd_Pc 0x8 then 0x20, Rd_Ctrl bit 8 set.
REQ-038 PC held at 0x40 for 4 cycles in CAPTURE -> Halted=1, State=STOPPED; Arm -> Halted=0, State=CAPTURE, entries retained.
REQ-039 Full buffer, Rd_Ready=1 with continuous captures -> Count stays 16, Dropped=0, pops in order; Flush mid-stream -> Count=0 next cycle.
REQ-040 Assert Rst asynchronously between edges during capture -> all outputs at REQ-033 values before next edge.
